ifetch_unit: RTL and testbench

Instruction fetch stage feeding the single-cycle datapath. Holds the PC and issues word requests to a variable-latency instruction memory. Presents the fetched instruction and pc_plus4 to decode/datapath. Resolves next-PC from the branch/jump controls and the zero flags, extended immediate and rS1 value that the datapath returns.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_unit_next_pc_sel.sv | 40 ++++
 rtl/ifetch_unit.sv | 152 +++++++++++++++
 tb/tb_ifetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned JIDX_W     = 26;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    ERROR = 3'd4
  } fetch_state_e;

  // True when a byte address sits on a word boundary.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_unit_next_pc_sel.sv
// Combinational next-PC target mux: jump_reg > jump > taken branch > sequential.
module next_pc_sel
  import ifetch_pkg::*;
(
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic              branch_z_i,
  input  logic              branch_nz_i,
  input  logic              jump_i,
  input  logic              jump_reg_i,
  input  logic              z_flag_i,
  input  logic              nz_flag_i,
  input  logic [XLEN-1:0]   ext_imm_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic [XLEN-1:0]   reg_target_i,
  output logic [XLEN-1:0]   next_pc_o,
  output logic              misalign_o
);

  logic            taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jmp_target;

  always_comb begin
    taken      = (branch_z_i & z_flag_i) | (branch_nz_i & nz_flag_i);
    br_target  = pc_plus4_i + (ext_imm_i << 2);
    jmp_target = {pc_plus4_i[XLEN-1:XLEN-4], jump_index_i, 2'b00};

    next_pc_o = pc_plus4_i;
    if (jump_reg_i) begin
      next_pc_o = reg_target_i;
    end else if (jump_i) begin
      next_pc_o = jmp_target;
    end else if (taken) begin
      next_pc_o = br_target;
    end

    misalign_o = !is_word_aligned(next_pc_o);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, drives a variable-latency imem handshake
// and resolves next-PC when the datapath commits the current instruction.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   instr,
  output logic              instr_valid,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  input  logic              instr_ack,
  input  logic              branch_z,
  input  logic              branch_nz,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              z_flag,
  input  logic              nz_flag,
  input  logic [XLEN-1:0]   ext_imm,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [XLEN-1:0]   reg_target,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] cnt_inc;

  logic [XLEN-1:0]   next_pc;
  logic              next_misalign;

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i   (pc4_q),
    .branch_z_i   (branch_z),
    .branch_nz_i  (branch_nz),
    .jump_i       (jump),
    .jump_reg_i   (jump_reg),
    .z_flag_i     (z_flag),
    .nz_flag_i    (nz_flag),
    .ext_imm_i    (ext_imm),
    .jump_index_i (jump_index),
    .reg_target_i (reg_target),
    .next_pc_o    (next_pc),
    .misalign_o   (next_misalign)
  );

  // Next-state and registered-output logic; outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + WAIT_W'(1);

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == WAIT_W'(MAX_WAIT)) begin
            state_d = ERROR;
          end
        end
      end
      VALID: begin
        if (instr_ack) begin
          // A misaligned target is never committed to the PC.
          if (next_misalign) begin
            state_d = ERROR;
          end else begin
            pc_d    = next_pc;
            pc4_d   = next_pc + XLEN'(WORD_BYTES);
            state_d = REQ;
          end
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase

    if (state_d == REQ) begin
      addr_d = pc_d;
    end

    req_d   = (state_d == REQ);
    valid_d = (state_d == VALID);
    err_d   = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + XLEN'(WORD_BYTES);
      instr_q <= '0;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc4_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit with a bench-side memory and next-PC model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 15;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] p4;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack = 1'b0;
  logic        branch_z = 1'b0;
  logic        branch_nz = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic        z_flag = 1'b0;
  logic        nz_flag = 1'b0;
  logic [31:0] ext_imm = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] reg_target = '0;
  logic        fetch_err;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          run_en = 1'b0;
  bit          junk_shot = 1'b0;
  int          next_lat = 2;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] exp_req_q[$];
  fetch_t      exp_fetch_q[$];

  // memory-side bookkeeping
  bit          pend = 1'b0;
  int          pend_cnt = 0;

  // monitor-side bookkeeping
  bit          prev_valid = 1'b0;
  fetch_t      held;

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_ack   (instr_ack),
    .branch_z    (branch_z),
    .branch_nz   (branch_nz),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .z_flag      (z_flag),
    .nz_flag     (nz_flag),
    .ext_imm     (ext_imm),
    .jump_index  (jump_index),
    .reg_target  (reg_target),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Next PC from the architectural rules; c = {jr, j, bz, bnz, z, nz}.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [5:0] c,
                                           input logic [31:0] imm, input logic [25:0] idx,
                                           input logic [31:0] rt);
    logic [31:0] seq_pc;
    seq_pc = cur + 32'd4;
    if (c[5]) return rt;
    if (c[4]) return {seq_pc[31:28], idx, 2'b00};
    if ((c[3] && c[1]) || (c[2] && c[0])) return seq_pc + imm * 32'd4;
    return seq_pc;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_event(input string name, input logic [95:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic drive_junk();
    instr_ack  = 1'($urandom);
    branch_z   = 1'($urandom);
    branch_nz  = 1'($urandom);
    jump       = 1'($urandom);
    jump_reg   = 1'($urandom);
    z_flag     = 1'($urandom);
    nz_flag    = 1'($urandom);
    ext_imm    = $urandom;
    jump_index = 26'($urandom);
    reg_target = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc",    96'(pc),                                  96'(RESET_PC));
    chk("rst_addr",  96'(imem_addr),                           96'(RESET_PC));
    chk("rst_instr", 96'(instr),                               96'(0));
    chk("rst_flags", 96'({instr_valid, imem_req, fetch_err}),  96'(0));
    repeat (3) @(negedge clk);
    exp_req_q.delete();
    exp_fetch_q.delete();
    model_pc = RESET_PC;
    exp_req_q.push_back(RESET_PC);
    next_lat = 2;
    junk_shot = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait for a presented instruction, stall, then ack with the given controls.
  task automatic do_fetch(input int stall, input logic [5:0] ctl, input logic [31:0] imm,
                          input logic [25:0] idx, input logic [31:0] rt, input int lat);
    int          w;
    logic [31:0] tgt;
    logic [31:0] old_pc;
    w = 0;
    while (instr_valid !== 1'b1 && w < 80) begin
      drive_junk();
      @(negedge clk);
      w++;
    end
    if (instr_valid !== 1'b1) begin
      flag_event("valid_timeout", 96'(w));
      finish_run();
      return;
    end
    for (int s = 0; s < stall; s++) begin
      drive_junk();
      instr_ack = 1'b0;
      @(negedge clk);
    end
    {jump_reg, jump, branch_z, branch_nz, z_flag, nz_flag} = ctl;
    ext_imm    = imm;
    jump_index = idx;
    reg_target = rt;
    instr_ack  = 1'b1;
    next_lat   = lat;
    old_pc     = model_pc;
    tgt        = ref_next(model_pc, ctl, imm, idx, rt);
    if (tgt[1:0] == 2'b00) begin
      model_pc = tgt;
      exp_req_q.push_back(tgt);
    end
    @(negedge clk);
    instr_ack = 1'b0;
    if (tgt[1:0] != 2'b00) begin
      chk("misalign_err", 96'({fetch_err, instr_valid, imem_req}), 96'(3'b100));
      chk("misalign_pc",  96'(pc), 96'(old_pc));
      do_reset();
    end else if (lat == 0) begin
      chk("timeout_req", 96'(imem_req), 96'(1));
      w = 0;
      while (fetch_err !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("timeout_cycles", 96'(w), 96'(MAX_WAIT + 1));
      junk_shot = 1'b1;
      repeat (3) @(negedge clk);
      chk("err_sticky", 96'({fetch_err, instr_valid, imem_req}), 96'(3'b100));
      do_reset();
    end
  endtask

  // Instruction memory: answers each request after next_lat cycles (0 = never) and
  // injects stray rvalids in states where the fetch unit must ignore them.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (junk_shot) begin
      imem_rvalid = 1'b1;
      junk_shot   = 1'b0;
    end else if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend        = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(model_pc);
        exp_fetch_q.push_back('{ins: mem_word(model_pc), pc: model_pc, p4: model_pc + 32'd4});
      end
    end else if (imem_req === 1'b1) begin
      if (next_lat > 0) begin
        pend     = 1'b1;
        pend_cnt = next_lat;
      end
      if ($urandom_range(0, 3) == 0) imem_rvalid = 1'b1;
    end else if (instr_valid === 1'b1 && $urandom_range(0, 2) == 0) begin
      imem_rvalid = 1'b1;
    end
  end

  // Monitor: every request address and every presented instruction against the queues.
  always @(negedge clk) begin
    if (!rst_n || !run_en) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_req === 1'b1) begin
        if (exp_req_q.size() == 0) flag_event("unexpected_req", 96'(imem_addr));
        else chk("req_addr", 96'(imem_addr), 96'(exp_req_q.pop_front()));
      end
      if (instr_valid === 1'b1 && !prev_valid) begin
        if (exp_fetch_q.size() == 0) begin
          flag_event("unexpected_valid", 96'(instr));
        end else begin
          held = exp_fetch_q.pop_front();
          chk("fetch", {instr, pc, pc_plus4}, held);
        end
      end else if (instr_valid === 1'b1) begin
        chk("hold", {instr, pc, pc_plus4}, held);
      end
      prev_valid = (instr_valid === 1'b1);
    end
  end

  initial begin
    int          w;
    logic [5:0]  ctl;
    logic [31:0] rt;
    int          lat;

    do_reset();
    run_en = 1'b1;

    do_fetch(0, 6'b000000, 32'h0, 26'h0, 32'h0, 3);
    do_fetch(0, 6'b100000, 32'h0, 26'h0, 32'h0000_0100, 1);
    do_fetch(0, 6'b001010, 32'hFFFF_FFFE, 26'h0, 32'h0, 2);
    do_fetch(0, 6'b100000, 32'h0, 26'h0, 32'h0000_0100, 1);
    do_fetch(0, 6'b001000, 32'hFFFF_FFFE, 26'h0, 32'h0, 1);
    do_fetch(0, 6'b100000, 32'h0, 26'h0, 32'h1000_0040, 1);
    do_fetch(0, 6'b010000, 32'h0, 26'h000_0010, 32'h0, 1);
    do_fetch(0, 6'b110000, 32'h0, 26'h000_0010, 32'h0000_0200, 2);
    do_fetch(10, 6'b000000, 32'h0, 26'h0, 32'h0, 15);
    do_fetch(0, 6'b001101, 32'h0000_0003, 26'h0, 32'h0, 1);
    do_fetch(0, 6'b000000, 32'h0, 26'h0, 32'h0, 0);
    do_fetch(0, 6'b100000, 32'h0, 26'h0, 32'h0000_0203, 1);
    do_fetch(0, 6'b100000, 32'h0, 26'h0, 32'hFFFF_FFFC, 2);
    do_fetch(0, 6'b000000, 32'h0, 26'h0, 32'h0, 2);
    do_fetch(0, 6'b000000, 32'h0, 26'h0, 32'h0, 12);

    // Reset while a response is still outstanding.
    w = 0;
    while (imem_req !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    do_reset();

    for (int i = 0; i < 120; i++) begin
      ctl = {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 4'($urandom)};
      rt  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) rt = rt | 32'h1;
      lat = ($urandom_range(0, 14) == 0) ? 15 : int'($urandom_range(1, 6));
      do_fetch(int'($urandom_range(0, 3)), ctl, $urandom_range(0, 128) - 32'd64,
               26'($urandom), rt, lat);
    end

    repeat (20) @(negedge clk);
    finish_run();
  end

endmodule
